mux41_rr_arbiter: RTL
=====================

Name: mux41_rr_arbiter

Overview:
- Shares one 4:1 data mux between four valid/ready requesters using round-robin arbitration.
- Drives the mux select, registers the selected word into a one-entry output stage, and returns per-requester ready.
- Sits in front of any single-consumer resource (bus, FIFO, serializer) that must accept traffic from four sources.

Parameters:
- DW, 8, data width of each requester and of the output.
- SELW, 2, select width (fixed at 2; exposed for package consistency only).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-requester valid; bit i is requester i.
- in_data  input  4*DW  packed data; requester i occupies bits [i*DW +: DW].
- in_last  input  4  end-of-burst marker; used only with BURST_LOCK_EN, ignored otherwise.
- in_ready  output  4  one-hot (or zero) accept strobe to requesters.
- out_valid  output  1  output word valid.
- out_data  output  DW  registered mux output.
- out_sel  output  2  index of the requester whose word is in out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=2'b00, priority pointer ptr=0, state=IDLE. in_ready is 0 while rst=1.
- accept_slot = !out_valid || out_ready; the output register is empty, or drains this cycle.
- Winner selection: the first i with in_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4. If no bit is set, there is no winner.
- in_ready[winner] = accept_slot && any in_valid. This is combinational from in_valid/state/out_ready; all other in_ready bits are 0. At most one bit is set.
- Transfer on requester i: in_valid[i] && in_ready[i]. On that clock edge:
  - out_data <= in_data[i];
  - out_sel <= i;
  - out_valid <= 1;
  - ptr <= (i+1) mod 4, which wraps 3 to 0.
- Output handshake: when out_valid && out_ready and there is no new transfer, out_valid <= 0. When a drain and a new transfer occur in the same cycle, out_valid stays 1 and data is replaced. Sustained throughput is 1 word/cycle.
- While out_valid && !out_ready: out_data and out_sel are held stable and in_ready = 0.
- Latency: in_valid/in_ready handshake to out_valid is 1 cycle.
- Fairness: with all four requesting continuously and out_ready=1, the grant order is 0,1,2,3,0,…
- A requester deasserting in_valid before its grant loses no priority; ptr moves only on a transfer.
- FSM states:
  - IDLE: out_valid=0. Goes to BUSY on a transfer.
  - BUSY: out_valid=1. Goes to IDLE on drain with no transfer; stays in BUSY on drain with a transfer, or when there is no drain.
  - LOCK: only with BURST_LOCK_EN. See Optional Feature.
- Reset mid-operation: the pending output word is discarded, out_valid drops immediately, and ptr returns to 0.

Optional Feature:
- Macro: MUX41_ARB_BURST_LOCK_EN.
- Defined:
  - A transfer from requester i with in_last[i]=0 enters LOCK with lock_id=i.
  - In LOCK the winner is forced to lock_id, regardless of ptr or other in_valid. If in_valid[lock_id]=0, no grant is issued.
  - ptr is not updated until the transfer with in_last[lock_id]=1, which returns the FSM to BUSY and sets ptr <= lock_id+1.
  - Reset clears the lock.
- Undefined: in_last is ignored, there is no LOCK state, and every word is arbitrated independently.

Decomposition:
- Package mux41_arb_pkg holds:
  - state typedef/localparams: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_LOCK=2'd2;
  - NUM_REQ=4 and SELW=2;
  - a constant function for the rotate-mod-4 index.
- Sub-module rr_pick4: purely combinational. Inputs are req[3:0] and ptr[1:0]; outputs are gnt_idx[1:0] and gnt_any. It is reused for the mux select.

Test Plan:
- Single requester: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1. Expect in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2; ptr becomes 3.
- Round-robin: all four valid with data 8'h10..8'h13, out_ready=1 for 8 cycles. Expect out_sel sequence 0,1,2,3,0,1,2,3 and out_data matching each.
- Backpressure: capture 8'h11 from requester 1, then hold out_ready=0 for 3 cycles. Expect in_ready=0, out_data=8'h11, out_valid=1 stable; one cycle after out_ready=1, the next winner is 2.
- Wrap and skip: ptr=3, in_valid=4'b0011. Expect grant to 0, then 1; requesters 2 and 3 are skipped with no bubble.
- Async reset mid-stream: assert rst between clock edges while out_valid=1. Expect out_valid=0 and in_ready=0 immediately; after release, the first grant follows ptr=0 order.
- With MUX41_ARB_BURST_LOCK_EN: requester 1 sends 3 words, last on the third, while requester 2 also requests. Expect out_sel=1,1,1,2.

Source files
------------

// File: rtl/mux41_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux41_arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SELW    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_LOCK = 2'd2
   } state_e;

   // Requester index "step" positions after "base"; 2-bit add wraps mod 4.
   function automatic logic [SELW-1:0] rot_idx(input logic [SELW-1:0] base,
                                               input logic [SELW-1:0] step);
      return base + step;
   endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, mod 4.
module rr_pick4
   import mux41_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SELW-1:0]    ptr,
   output logic [SELW-1:0]    gnt_idx,
   output logic               gnt_any
);

   logic [SELW-1:0] idx;

   // Scan from farthest to nearest so the closest request to ptr wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx = rot_idx(ptr, SELW'(k));
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux into a one-entry output stage.
// Optional burst locking is enabled by defining MUX41_ARB_BURST_LOCK_EN.
module mux41_rr_arbiter #(
   parameter int unsigned DW   = 8,
   parameter int unsigned SELW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      in_valid,
   input  logic [4*DW-1:0] in_data,
   input  logic [3:0]      in_last,
   output logic [3:0]      in_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [SELW-1:0] out_sel,
   input  logic            out_ready
);

   import mux41_arb_pkg::*;

   state_e          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic [SELW-1:0] out_sel_q, out_sel_d;

   logic [1:0]      pick_idx, win_idx;
   logic            pick_any, win_any;
   logic            accept_slot, xfer;
   logic [DW-1:0]   win_data;

   rr_pick4 u_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

`ifdef MUX41_ARB_BURST_LOCK_EN
   logic [1:0] lock_id_q, lock_id_d;

   // While locked, only the burst owner may be granted.
   always_comb begin
      win_idx = pick_idx;
      win_any = pick_any;
      if (state_q == ST_LOCK) begin
         win_idx = lock_id_q;
         win_any = in_valid[lock_id_q];
      end
   end
`else
   logic unused_last;
   assign unused_last = ^in_last;
   assign win_idx     = pick_idx;
   assign win_any     = pick_any;
`endif

   assign accept_slot = !out_valid_q || out_ready;

   always_comb begin
      in_ready = '0;
      if (!rst && accept_slot && win_any) begin
         in_ready[win_idx] = 1'b1;
      end
   end

   assign xfer = |in_ready;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win_idx == 2'(i)) begin
            win_data = in_data[i*DW +: DW];
         end
      end
   end

   // Next-state for the output stage, pointer and FSM.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
`ifdef MUX41_ARB_BURST_LOCK_EN
      lock_id_d   = lock_id_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = win_data;
         out_sel_d   = SELW'(win_idx);
         state_d     = ST_BUSY;
         ptr_d       = rot_idx(win_idx, 2'd1);
`ifdef MUX41_ARB_BURST_LOCK_EN
         // A non-last word opens or continues a burst; ptr freezes until it ends.
         if (!in_last[win_idx]) begin
            state_d   = ST_LOCK;
            lock_id_d = win_idx;
            ptr_d     = ptr_q;
         end
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         if (state_q != ST_LOCK) begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
`ifdef MUX41_ARB_BURST_LOCK_EN
         lock_id_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
`ifdef MUX41_ARB_BURST_LOCK_EN
         lock_id_q   <= lock_id_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
